read_ptr_scheduler: RTL and testbench

READ_PTR_SCHEDULER -- requirements
Module: read_ptr_scheduler

---
 rtl/read_ptr_scheduler.sv | 158 +++++++++++++++
 tb/tb_read_ptr_scheduler.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_ptr_scheduler.sv
// Read-pointer scheduler: arbitrates software (edge) and hardware (level) increment
// requests round-robin, strobes the buffer read, then advances rd_ptr; Avalon-MM control.
module read_ptr_scheduler #(
    parameter int PTR_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sw_inc,
    input  logic             hw_inc_req,
    output logic             hw_inc_ack,
    input  logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             rd_en,
    output logic             empty,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             enable_reg;
    logic             sw_pend_reg;
    logic             udf_err_reg;
    logic             ovf_err_reg;
    logic             last_grant_sw_reg;
    logic             grant_sw_reg;
    logic             sw_inc_reg;
    logic             sw_armed_reg;
    logic [CNT_W-1:0] svc_cnt_reg;
    logic [PTR_W-1:0] rd_ptr_reg;

    logic sw_edge;
    logic pick_sw;
    logic issue;
    logic udf_drop;
    logic busy;
    logic wr_en;
    logic wr_ctrl;
    logic wr_load;
    logic wr_cnt;
    logic unused_bits;

    // A level still high from before reset is not an edge until a low has been seen.
    assign sw_edge  = sw_inc && !sw_inc_reg && sw_armed_reg;
    assign empty    = (rd_ptr_reg == wr_ptr);
    assign pick_sw  = sw_pend_reg && (!hw_inc_req || !last_grant_sw_reg);
    assign issue    = (state_reg == IDLE) && enable_reg && (sw_pend_reg || hw_inc_req) && !empty;
    assign udf_drop = (state_reg == IDLE) && enable_reg && sw_pend_reg && empty;

    assign wr_en   = chipselect && !write_n;
    assign wr_ctrl = wr_en && (address == 2'd0);
    assign wr_load = wr_en && (address == 2'd2);
    assign wr_cnt  = wr_en && (address == 2'd3);

    assign rd_ptr      = rd_ptr_reg;
    assign unused_bits = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (issue) state_next = READ;
            READ:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en      = (state_reg == READ);
        hw_inc_ack = (state_reg == ACK) && !grant_sw_reg;
        busy       = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_reg        <= 1'b0;
            sw_pend_reg       <= 1'b0;
            udf_err_reg       <= 1'b0;
            ovf_err_reg       <= 1'b0;
            last_grant_sw_reg <= 1'b0;
            grant_sw_reg      <= 1'b0;
            sw_inc_reg        <= 1'b0;
            sw_armed_reg      <= 1'b0;
            svc_cnt_reg       <= '0;
            rd_ptr_reg        <= '0;
        end else begin
            sw_inc_reg <= sw_inc;
            if (!sw_inc) sw_armed_reg <= 1'b1;

            if (wr_ctrl) enable_reg <= writedata[0];

            if (issue) begin
                grant_sw_reg      <= pick_sw;
                last_grant_sw_reg <= pick_sw;
            end

            if (sw_edge && !sw_pend_reg)
                sw_pend_reg <= 1'b1;
            else if (udf_drop || ((state_reg == ACK) && grant_sw_reg))
                sw_pend_reg <= 1'b0;

            // Setting an error takes priority over a same-cycle clear.
            if (sw_edge && sw_pend_reg)
                ovf_err_reg <= 1'b1;
            else if (wr_ctrl && writedata[2])
                ovf_err_reg <= 1'b0;

            if (udf_drop)
                udf_err_reg <= 1'b1;
            else if (wr_ctrl && writedata[1])
                udf_err_reg <= 1'b0;

            if (state_reg == ACK)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            else if (wr_load && !enable_reg && (state_reg == IDLE))
                rd_ptr_reg <= writedata[PTR_W-1:0];

            if (wr_cnt)
                svc_cnt_reg <= '0;
            else if (state_reg == ACK)
                svc_cnt_reg <= svc_cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[0] = enable_reg;
            2'd1: begin
                readdata[PTR_W-1:0] = rd_ptr_reg;
                readdata[16]        = empty;
                readdata[17]        = udf_err_reg;
                readdata[18]        = ovf_err_reg;
                readdata[19]        = sw_pend_reg;
                readdata[20]        = busy;
            end
            2'd2:    readdata[PTR_W-1:0] = rd_ptr_reg;
            default: readdata[CNT_W-1:0] = svc_cnt_reg;
        endcase
    end
endmodule

// File: tb/tb_read_ptr_scheduler.sv
// Self-checking bench for read_ptr_scheduler: register-map vector table, directed
// multi-cycle sequences, and a randomized run against a pointer/service scoreboard.
module tb_read_ptr_scheduler;
    localparam int PTR_W = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             sw_inc = 1'b0;
    logic             hw_inc_req = 1'b0;
    logic             hw_inc_ack;
    logic [PTR_W-1:0] wr_ptr = '0;
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_en;
    logic             empty;
    logic [1:0]       address = 2'd0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    read_ptr_scheduler #(.PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_inc     (sw_inc),
        .hw_inc_req (hw_inc_req),
        .hw_inc_ack (hw_inc_ack),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .rd_en      (rd_en),
        .empty      (empty),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               c;
        logic [PTR_W-1:0] p;
    } ev_t;
    ev_t rd_q[$];
    ev_t ack_q[$];

    always @(negedge clk) begin
        if (rd_en)      rd_q.push_back('{c: cyc, p: rd_ptr});
        if (hw_inc_ack) ack_q.push_back('{c: cyc, p: rd_ptr});
    end

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                         input bit quiet = 1'b0);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else if (!quiet) begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; sw_inc = 1'b0; hw_inc_req = 1'b0; wr_ptr = '0;
        chipselect = 1'b0; write_n = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic pulse_sw();
        sw_inc = 1'b1;
        tick();
        sw_inc = 1'b0;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        ack_q.delete();
    endtask

    // Returns on the falling edge of the first READ cycle seen, or after the bound.
    task automatic wait_rd_en(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rd_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        bit          ok;
        int          c0;
        int          starts[3];

        // ---------------- register map vector table ----------------
        vecs[0]  = '{2'd0, 1'b0, 32'h0,   32'h0};
        vecs[1]  = '{2'd1, 1'b0, 32'h0,   32'h10000};
        vecs[2]  = '{2'd2, 1'b0, 32'h0,   32'h0};
        vecs[3]  = '{2'd3, 1'b0, 32'h0,   32'h0};
        vecs[4]  = '{2'd2, 1'b1, 32'h7,   32'h0};
        vecs[5]  = '{2'd2, 1'b0, 32'h0,   32'h7};
        vecs[6]  = '{2'd1, 1'b0, 32'h0,   32'h7};
        vecs[7]  = '{2'd0, 1'b1, 32'h1,   32'h0};
        vecs[8]  = '{2'd0, 1'b0, 32'h0,   32'h1};
        vecs[9]  = '{2'd2, 1'b1, 32'h9,   32'h0};
        vecs[10] = '{2'd2, 1'b0, 32'h0,   32'h7};
        vecs[11] = '{2'd0, 1'b1, 32'h6,   32'h0};
        vecs[12] = '{2'd0, 1'b0, 32'h0,   32'h0};
        vecs[13] = '{2'd2, 1'b1, 32'h1FF, 32'h0};
        vecs[14] = '{2'd1, 1'b0, 32'h0,   32'hFF};
        vecs[15] = '{2'd2, 1'b1, 32'h0,   32'h0};
        vecs[16] = '{2'd1, 1'b0, 32'h0,   32'h10000};

        do_reset();
        check("reset rd_ptr", 32'(rd_ptr), 32'h0);
        check("reset rd_en", 32'(rd_en), 32'h0);
        check("reset hw_inc_ack", 32'(hw_inc_ack), 32'h0);
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) begin
                av_write(vecs[i].addr, vecs[i].data);
            end else begin
                av_read(vecs[i].addr, rd);
                check($sformatf("vec%0d addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
            end
        end

        // ---------------- three sw pulses, wr_ptr=5 ----------------
        do_reset();
        wr_ptr = 8'd5;
        av_write(2'd0, 32'h1);
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            starts[k] = cyc;
            pulse_sw();
            tick(3);
        end
        tick(2);
        check("sw rd_en count", 32'(rd_q.size()), 32'd3);
        for (int k = 0; k < 3 && k < rd_q.size(); k++) begin
            check($sformatf("sw rd_ptr #%0d", k), 32'(rd_q[k].p), 32'(k));
            check($sformatf("sw latency #%0d", k), 32'(rd_q[k].c - starts[k]), 32'd2);
        end
        check("sw no hw ack", 32'(ack_q.size()), 32'd0);
        av_read(2'd3, rd);
        check("sw svc_cnt", rd, 32'd3);

        // ---------------- hw held, wr_ptr=2 then 3 ----------------
        do_reset();
        av_write(2'd0, 32'h1);
        wr_ptr = 8'd2;
        clear_logs();
        c0 = cyc;
        hw_inc_req = 1'b1;
        tick(12);
        check("hw ack count stalled", 32'(ack_q.size()), 32'd2);
        if (ack_q.size() >= 2) begin
            check("hw ack ptr 0", 32'(ack_q[0].p), 32'd0);
            check("hw ack ptr 1", 32'(ack_q[1].p), 32'd1);
        end
        if (rd_q.size() >= 1) check("hw latency", 32'(rd_q[0].c - c0), 32'd1);
        check("hw stall empty", 32'(empty), 32'd1);
        av_read(2'd1, rd);
        check("hw stall status", rd, 32'h10002);
        wr_ptr = 8'd3;
        tick(6);
        check("hw ack count resumed", 32'(ack_q.size()), 32'd3);
        if (ack_q.size() >= 3) check("hw ack ptr 2", 32'(ack_q[2].p), 32'd2);
        hw_inc_req = 1'b0;

        // ---------------- round robin with both pending ----------------
        do_reset();
        wr_ptr = 8'd100;
        pulse_sw();
        hw_inc_req = 1'b1;
        tick(2);
        av_write(2'd0, 32'h1);
        clear_logs();
        for (int i = 0; i < 30; i++) begin
            av_read(2'd1, rd);
            sw_inc = (!rd[19] && !sw_inc);
            tick();
        end
        sw_inc = 1'b0;
        hw_inc_req = 1'b0;
        tick(4);
        check("rr grant count >= 6", 32'(rd_q.size() >= 6), 32'd1);
        for (int g = 0; g < 6 && g < rd_q.size(); g++) begin
            bit is_hw;
            is_hw = 1'b0;
            foreach (ack_q[j]) if (ack_q[j].c == rd_q[g].c + 1) is_hw = 1'b1;
            check($sformatf("rr grant #%0d is_hw", g), 32'(is_hw), 32'(g % 2));
        end

        // ---------------- wrap 254 -> 2, stall at 3 ----------------
        do_reset();
        av_write(2'd2, 32'd254);
        av_write(2'd0, 32'h1);
        wr_ptr = 8'd3;
        clear_logs();
        hw_inc_req = 1'b1;
        tick(25);
        hw_inc_req = 1'b0;
        check("wrap ack count", 32'(ack_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < ack_q.size(); k++)
            check($sformatf("wrap ack ptr #%0d", k), 32'(ack_q[k].p), 32'((254 + k) % 256));
        check("wrap final rd_ptr", 32'(rd_ptr), 32'd3);
        check("wrap final empty", 32'(empty), 32'd1);

        // ---------------- underflow / overflow errors ----------------
        do_reset();
        av_write(2'd0, 32'h1);
        clear_logs();
        pulse_sw();
        tick(5);
        check("udf no rd_en", 32'(rd_q.size()), 32'd0);
        av_read(2'd1, rd);
        check("udf status", rd, 32'h30000);
        av_write(2'd0, 32'h3);
        av_read(2'd0, rd);
        check("udf clear ctrl", rd, 32'h1);
        av_read(2'd1, rd);
        check("udf cleared status", rd, 32'h10000);
        sw_inc = 1'b1;
        tick();
        sw_inc = 1'b0;
        av_write(2'd0, 32'h3);
        av_read(2'd1, rd);
        check("udf set beats clear", rd, 32'h30000);
        av_write(2'd0, 32'h2);
        pulse_sw();
        tick();
        pulse_sw();
        tick();
        av_read(2'd1, rd);
        check("ovf status", rd, 32'hD0000);
        av_write(2'd0, 32'h4);
        av_read(2'd1, rd);
        check("ovf cleared status", rd, 32'h90000);

        // ---------------- reset during READ ----------------
        pulse_sw();
        tick();
        av_read(2'd1, rd);
        check("ovf again status", rd, 32'hD0000);
        av_write(2'd2, 32'd10);
        wr_ptr = 8'd20;
        av_write(2'd0, 32'h1);
        wait_rd_en(10, ok);
        check("pre-reset READ seen", 32'(ok), 32'd1);
        check("pre-reset rd_ptr", 32'(rd_ptr), 32'd10);
        reset_n = 1'b0;
        #1;
        check("abort rd_ptr", 32'(rd_ptr), 32'd0);
        check("abort rd_en", 32'(rd_en), 32'd0);
        av_read(2'd1, rd);
        check("abort status", rd, 32'h0);
        av_read(2'd0, rd);
        check("abort ctrl", rd, 32'h0);
        sw_inc = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(4);
        av_read(2'd1, rd);
        check("held sw not an edge", rd, 32'h0);
        sw_inc = 1'b0;
        tick();
        sw_inc = 1'b1;
        tick(2);
        sw_inc = 1'b0;
        av_read(2'd1, rd);
        check("sw edge after release", rd, 32'h80000);

        // ---------------- svc_cnt clear beats increment ----------------
        do_reset();
        av_write(2'd0, 32'h1);
        wr_ptr = 8'd50;
        clear_logs();
        hw_inc_req = 1'b1;
        wait_rd_en(10, ok);
        check("svc READ seen", 32'(ok), 32'd1);
        tick();
        address = 2'd3; chipselect = 1'b1; write_n = 1'b0; hw_inc_req = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
        tick(2);
        check("svc ack count", 32'(ack_q.size()), 32'd1);
        av_read(2'd3, rd);
        check("svc clear wins", rd, 32'h0);
        av_read(2'd2, rd);
        check("svc rd_ptr advanced", rd, 32'h1);

        // ---------------- randomized scoreboard ----------------
        begin
            logic [PTR_W-1:0] exp_ptr;
            int               n_rd;
            bit               prev_rd;
            bit               ack_seen;
            int               hw_wait;
            int               max_wait;
            exp_ptr = '0; n_rd = 0; prev_rd = 1'b0; ack_seen = 1'b0;
            hw_wait = 0; max_wait = 0;
            do_reset();
            av_write(2'd0, 32'h1);
            for (int i = 0; i < 800; i++) begin
                if (hw_inc_req && ack_seen) begin
                    hw_inc_req = 1'b0;
                end else if (!hw_inc_req && ($urandom % 4 == 0)) begin
                    hw_inc_req = 1'b1;
                end
                sw_inc = ($urandom % 6 == 0);
                if ($urandom % 12 == 0) wr_ptr = PTR_W'(exp_ptr + $urandom_range(0, 8));
                @(negedge clk);
                check("rand empty", 32'(empty), 32'(rd_ptr == wr_ptr), 1'b1);
                if (rd_en) begin
                    check("rand rd_ptr", 32'(rd_ptr), 32'(exp_ptr), 1'b1);
                    check("rand rd_en not empty", 32'(rd_ptr != wr_ptr), 32'd1, 1'b1);
                    exp_ptr = exp_ptr + 1'b1;
                    n_rd++;
                end
                if (hw_inc_ack) begin
                    check("rand ack after read", 32'(prev_rd), 32'd1, 1'b1);
                    check("rand ack with req", 32'(hw_inc_req), 32'd1, 1'b1);
                end
                ack_seen = hw_inc_ack;
                prev_rd  = rd_en;
                hw_wait  = (hw_inc_req && !hw_inc_ack) ? hw_wait + 1 : 0;
                if (hw_wait > max_wait) max_wait = hw_wait;
                @(posedge clk);
                #1;
            end
            hw_inc_req = 1'b0;
            sw_inc = 1'b0;
            tick(5);
            check("rand hw wait bounded", 32'(max_wait <= 300), 32'd1);
            check("rand some reads", 32'(n_rd > 20), 32'd1);
            av_read(2'd3, rd);
            check("rand svc_cnt", rd, 32'(n_rd % 65536));
            av_read(2'd2, rd);
            check("rand final rd_ptr", rd, 32'(exp_ptr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
